// File: rtl/bound_pkg.sv
// Shared definitions for the bound stage: config modes and saturation limits.
package bound_pkg;

    typedef enum logic [1:0] {
        MODE_SAT        = 2'b00,
        MODE_RELU       = 2'b01,
        MODE_SHIFT      = 2'b10,
        MODE_RELU_SHIFT = 2'b11
    } bound_mode_e;

    // Default output width and the working width used for clipping.
    localparam int DEF_D_BW = 8;
    localparam int CLIP_W   = 64;

    // Largest value representable in a bw-bit signed word.
    function automatic logic signed [CLIP_W-1:0] d_max(input int unsigned bw);
        logic signed [CLIP_W-1:0] one;
        one = 64'sd1;
        return (one <<< (bw - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a bw-bit signed word.
    function automatic logic signed [CLIP_W-1:0] d_min(input int unsigned bw);
        logic signed [CLIP_W-1:0] one;
        one = 64'sd1;
        return -(one <<< (bw - 1));
    endfunction

    // Clip a signed value into the bw-bit signed range.
    function automatic logic signed [CLIP_W-1:0] clip(input logic signed [CLIP_W-1:0] v,
                                                      input int unsigned bw);
        if (v > d_max(bw)) begin
            return d_max(bw);
        end else if (v < d_min(bw)) begin
            return d_min(bw);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/bound_lane.sv
// One channel of the bound stage: ReLU / rounding shift in stage 1,
// saturation to D_BW with a clip flag in stage 2.
module bound_lane
    import bound_pkg::*;
#(
    parameter int AB_BW = 21,
    parameter int D_BW  = DEF_D_BW,
    parameter int SH_BW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cap,
    input  logic                adv,
    input  logic                relu_en,
    input  logic                shift_en,
    input  logic [SH_BW-1:0]    shift,
    input  logic [AB_BW-1:0]    acc_bias,
    output logic [D_BW-1:0]     data,
    output logic                sat
);

    localparam int YW = AB_BW + 1;

    logic signed [YW-1:0]     x_ext;
    logic signed [YW-1:0]     r;
    logic signed [YW-1:0]     rnd;
    logic signed [YW-1:0]     sum;
    logic signed [YW-1:0]     y_next;
    logic signed [YW-1:0]     s1_y;
    logic signed [CLIP_W-1:0] wide;
    logic signed [CLIP_W-1:0] clipped;
    logic [D_BW-1:0]          data_next;
    logic                     sat_next;

    // Stage-1 arithmetic: optional ReLU, then round-half-up arithmetic shift.
    always_comb begin
        x_ext  = {acc_bias[AB_BW-1], acc_bias};
        r      = (relu_en && x_ext < 0) ? '0 : x_ext;
        rnd    = '0;
        sum    = r;
        y_next = r;
        if (shift_en && shift != '0) begin
            rnd    = YW'(1) << (shift - 1'b1);
            sum    = r + rnd;
            y_next = sum >>> shift;
        end
    end

    // Stage-1 register, captured only when a beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_y <= '0;
        end else if (cap) begin
            s1_y <= y_next;
        end
    end

    // Stage-2 arithmetic: saturate to the output range and flag any change.
    always_comb begin
        wide      = CLIP_W'(s1_y);
        clipped   = clip(wide, D_BW);
        data_next = clipped[D_BW-1:0];
        sat_next  = (clipped != wide);
    end

    // Stage-2 register, holds while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            sat  <= 1'b0;
        end else if (adv) begin
            data <= data_next;
            sat  <= sat_next;
        end
    end

endmodule

// File: rtl/bound_array.sv
// NUM_CH-lane bound stage with latched config, 2-stage valid/ready pipeline
// and a saturating count of clipped lane values.
module bound_array
    import bound_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int AB_BW  = 21,
    parameter int D_BW   = DEF_D_BW,
    parameter int SH_BW  = 5,
    parameter int CNT_BW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cfg_load,
    input  logic [1:0]               i_cfg_mode,
    input  logic [SH_BW-1:0]         i_cfg_shift,
    output logic                     o_cfg_err,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_CH*AB_BW-1:0]  i_acc_bias,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NUM_CH*D_BW-1:0]   o_bound_data,
    output logic [CNT_BW-1:0]        o_sat_cnt,
    output logic                     o_busy
);

    bound_mode_e        cfg_mode;
    logic [SH_BW-1:0]   cfg_shift;
    logic               relu_en;
    logic               shift_en;
    logic               s1_v;
    logic               s2_v;
    logic               adv1;
    logic               adv2;
    logic               accept;
    logic               deliver;
    logic               s2_load;
    logic               cfg_ok;
    logic [NUM_CH-1:0]  sat;
    logic [CNT_BW:0]    pop;
    logic [CNT_BW:0]    cnt_sum;

    // Handshake and config-acceptance decode.
    always_comb begin
        adv2     = !s2_v || i_ready;
        adv1     = !s1_v || adv2;
        o_ready  = adv1;
        accept   = i_valid && adv1;
        deliver  = s2_v && i_ready;
        s2_load  = adv2 && s1_v;
        o_valid  = s2_v;
        o_busy   = s1_v || s2_v;
        cfg_ok   = i_cfg_load && !o_busy && !accept;
        relu_en  = (cfg_mode == MODE_RELU) || (cfg_mode == MODE_RELU_SHIFT);
        shift_en = (cfg_mode == MODE_SHIFT) || (cfg_mode == MODE_RELU_SHIFT);
    end

    // Pipeline stage valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (adv1) begin
                s1_v <= accept;
            end
            if (adv2) begin
                s2_v <= s1_v;
            end
        end
    end

    // Config registers; an oversize shift is clamped when loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_mode  <= MODE_SAT;
            cfg_shift <= '0;
            o_cfg_err <= 1'b0;
        end else begin
            o_cfg_err <= i_cfg_load && !cfg_ok;
            if (cfg_ok) begin
                cfg_mode <= bound_mode_e'(i_cfg_mode);
                if (32'(i_cfg_shift) >= 32'(AB_BW)) begin
                    cfg_shift <= SH_BW'(AB_BW - 1);
                end else begin
                    cfg_shift <= i_cfg_shift;
                end
            end
        end
    end

    // Popcount of the delivered beat's clip flags, added with saturation.
    always_comb begin
        pop = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            pop = pop + {{CNT_BW{1'b0}}, sat[k]};
        end
        cnt_sum = {1'b0, o_sat_cnt} + pop;
    end

    // Saturation counter: cleared by an accepted config load.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sat_cnt <= '0;
        end else if (cfg_ok) begin
            o_sat_cnt <= '0;
        end else if (deliver) begin
            o_sat_cnt <= cnt_sum[CNT_BW] ? '1 : cnt_sum[CNT_BW-1:0];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        bound_lane #(
            .AB_BW (AB_BW),
            .D_BW  (D_BW),
            .SH_BW (SH_BW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .cap      (accept),
            .adv      (s2_load),
            .relu_en  (relu_en),
            .shift_en (shift_en),
            .shift    (cfg_shift),
            .acc_bias (i_acc_bias[g*AB_BW +: AB_BW]),
            .data     (o_bound_data[g*D_BW +: D_BW]),
            .sat      (sat[g])
        );
    end

endmodule

// File: tb/tb_bound_array.sv
// Directed bench for bound_array with hand-computed expected values.
module tb_bound_array;

    localparam int NUM_CH = 3;
    localparam int AB_BW  = 21;
    localparam int D_BW   = 8;
    localparam int SH_BW  = 5;
    localparam int CNT_BW = 16;

    logic                    clk;
    logic                    rst;
    logic                    i_cfg_load;
    logic [1:0]              i_cfg_mode;
    logic [SH_BW-1:0]        i_cfg_shift;
    logic                    o_cfg_err;
    logic                    i_valid;
    logic                    o_ready;
    logic [NUM_CH*AB_BW-1:0] i_acc_bias;
    logic                    o_valid;
    logic                    i_ready;
    logic [NUM_CH*D_BW-1:0]  o_bound_data;
    logic [CNT_BW-1:0]       o_sat_cnt;
    logic                    o_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bound_array #(
        .NUM_CH (NUM_CH),
        .AB_BW  (AB_BW),
        .D_BW   (D_BW),
        .SH_BW  (SH_BW),
        .CNT_BW (CNT_BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cfg_load   (i_cfg_load),
        .i_cfg_mode   (i_cfg_mode),
        .i_cfg_shift  (i_cfg_shift),
        .o_cfg_err    (o_cfg_err),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_acc_bias   (i_acc_bias),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_bound_data (o_bound_data),
        .o_sat_cnt    (o_sat_cnt),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [NUM_CH*AB_BW-1:0] pin(input int a, input int b, input int c);
        logic [NUM_CH*AB_BW-1:0] v;
        v = {c[AB_BW-1:0], b[AB_BW-1:0], a[AB_BW-1:0]};
        return v;
    endfunction

    function automatic logic [NUM_CH*D_BW-1:0] pout(input int a, input int b, input int c);
        logic [NUM_CH*D_BW-1:0] v;
        v = {c[D_BW-1:0], b[D_BW-1:0], a[D_BW-1:0]};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int a, input int b, input int c);
        i_acc_bias = pin(a, b, c);
        i_valid    = 1'b1;
        tick();
        i_valid    = 1'b0;
        tick();
    endtask

    task automatic load_cfg(input logic [1:0] m, input logic [SH_BW-1:0] s);
        i_cfg_mode  = m;
        i_cfg_shift = s;
        i_cfg_load  = 1'b1;
        tick();
        i_cfg_load  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", o_valid); else pass_cnt++;
        total_cnt++; if (o_bound_data !== '0) $display("FAIL rst_data got=%h exp=0", o_bound_data); else pass_cnt++;
        total_cnt++; if (o_sat_cnt !== '0) $display("FAIL rst_satcnt got=%0d exp=0", o_sat_cnt); else pass_cnt++;
        total_cnt++; if (o_cfg_err !== 1'b0) $display("FAIL rst_cfgerr got=%0b exp=0", o_cfg_err); else pass_cnt++;
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", o_busy); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (o_ready !== 1'b1) $display("FAIL rst_ready got=%0b exp=1", o_ready); else pass_cnt++;
    endtask

    task automatic test_saturate();
        i_acc_bias = pin(32, -190, 120);
        i_valid    = 1'b1;
        tick();
        i_valid    = 1'b0;
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL sat_early_valid got=%0b exp=0", o_valid); else pass_cnt++;
        total_cnt++; if (o_busy !== 1'b1) $display("FAIL sat_busy got=%0b exp=1", o_busy); else pass_cnt++;
        tick();
        total_cnt++; if (o_valid !== 1'b1) $display("FAIL sat_valid got=%0b exp=1", o_valid); else pass_cnt++;
        total_cnt++; if (o_bound_data !== pout(32, -128, 120)) $display("FAIL sat_data got=%h exp=%h", o_bound_data, pout(32, -128, 120)); else pass_cnt++;
        tick();
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL sat_drain got=%0b exp=0", o_valid); else pass_cnt++;
        total_cnt++; if (o_sat_cnt !== 16'd1) $display("FAIL sat_cnt got=%0d exp=1", o_sat_cnt); else pass_cnt++;
    endtask

    task automatic test_relu_b2b();
        load_cfg(2'b01, 5'd0);
        total_cnt++; if (o_cfg_err !== 1'b0) $display("FAIL relu_cfgerr got=%0b exp=0", o_cfg_err); else pass_cnt++;
        total_cnt++; if (o_sat_cnt !== 16'd0) $display("FAIL relu_cnt_clear got=%0d exp=0", o_sat_cnt); else pass_cnt++;
        i_acc_bias = pin(-100, -33, 70);
        i_valid    = 1'b1;
        tick();
        i_acc_bias = pin(-10, 67, 30);
        tick();
        i_valid    = 1'b0;
        total_cnt++; if (o_valid !== 1'b1) $display("FAIL relu_valid_a got=%0b exp=1", o_valid); else pass_cnt++;
        total_cnt++; if (o_bound_data !== pout(0, 0, 70)) $display("FAIL relu_data_a got=%h exp=%h", o_bound_data, pout(0, 0, 70)); else pass_cnt++;
        tick();
        total_cnt++; if (o_valid !== 1'b1) $display("FAIL relu_valid_b got=%0b exp=1", o_valid); else pass_cnt++;
        total_cnt++; if (o_bound_data !== pout(0, 67, 30)) $display("FAIL relu_data_b got=%h exp=%h", o_bound_data, pout(0, 67, 30)); else pass_cnt++;
        tick();
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL relu_drain got=%0b exp=0", o_valid); else pass_cnt++;
        total_cnt++; if (o_sat_cnt !== 16'd0) $display("FAIL relu_cnt got=%0d exp=0", o_sat_cnt); else pass_cnt++;
    endtask

    task automatic test_shift();
        load_cfg(2'b10, 5'd2);
        send_beat(-17, -33, 31);
        total_cnt++; if (o_valid !== 1'b1) $display("FAIL sh2_valid got=%0b exp=1", o_valid); else pass_cnt++;
        total_cnt++; if (o_bound_data !== pout(-4, -8, 8)) $display("FAIL sh2_data got=%h exp=%h", o_bound_data, pout(-4, -8, 8)); else pass_cnt++;
        tick();
        load_cfg(2'b11, 5'd1);
        total_cnt++; if (o_cfg_err !== 1'b0) $display("FAIL rs1_cfgerr got=%0b exp=0", o_cfg_err); else pass_cnt++;
        send_beat(-17, -11, 5);
        total_cnt++; if (o_bound_data !== pout(0, 0, 3)) $display("FAIL rs1_data got=%h exp=%h", o_bound_data, pout(0, 0, 3)); else pass_cnt++;
        tick();
        total_cnt++; if (o_sat_cnt !== 16'd0) $display("FAIL rs1_cnt got=%0d exp=0", o_sat_cnt); else pass_cnt++;
        send_beat(300, -1, 0);
        total_cnt++; if (o_bound_data !== pout(127, 0, 0)) $display("FAIL rs1_clip_data got=%h exp=%h", o_bound_data, pout(127, 0, 0)); else pass_cnt++;
        tick();
        total_cnt++; if (o_sat_cnt !== 16'd1) $display("FAIL rs1_clip_cnt got=%0d exp=1", o_sat_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int sent;
        int recv;
        logic [NUM_CH*D_BW-1:0] held;
        logic acc;
        logic del;
        sent = 0;
        recv = 0;
        held = '0;
        load_cfg(2'b00, 5'd0);
        for (int cyc = 0; cyc < 30 && recv < 8; cyc++) begin
            i_ready    = !(cyc >= 3 && cyc <= 5);
            i_valid    = (sent < 8);
            i_acc_bias = pin(sent + 1, sent + 101, -(sent + 1));
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                total_cnt++; if (o_ready !== 1'b0) $display("FAIL bp_ready cyc=%0d got=%0b exp=0", cyc, o_ready); else pass_cnt++;
                total_cnt++; if (o_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%0b exp=1", cyc, o_valid); else pass_cnt++;
                if (cyc == 3) begin
                    held = o_bound_data;
                    total_cnt++; if (o_bound_data !== pout(recv + 1, recv + 101, -(recv + 1))) $display("FAIL bp_head got=%h exp=%h", o_bound_data, pout(recv + 1, recv + 101, -(recv + 1))); else pass_cnt++;
                end else begin
                    total_cnt++; if (o_bound_data !== held) $display("FAIL bp_hold cyc=%0d got=%h exp=%h", cyc, o_bound_data, held); else pass_cnt++;
                end
            end
            acc = i_valid && o_ready;
            del = o_valid && i_ready;
            if (del) begin
                total_cnt++; if (o_bound_data !== pout(recv + 1, recv + 101, -(recv + 1))) $display("FAIL bp_data idx=%0d got=%h exp=%h", recv, o_bound_data, pout(recv + 1, recv + 101, -(recv + 1))); else pass_cnt++;
                recv++;
            end
            if (acc) sent++;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        total_cnt++; if (recv !== 8) $display("FAIL bp_recv got=%0d exp=8", recv); else pass_cnt++;
        total_cnt++; if (o_sat_cnt !== 16'd0) $display("FAIL bp_cnt got=%0d exp=0", o_sat_cnt); else pass_cnt++;
    endtask

    task automatic test_cfg_busy();
        i_acc_bias = pin(-50, 10, 200);
        i_valid    = 1'b1;
        tick();
        i_valid     = 1'b0;
        i_cfg_mode  = 2'b01;
        i_cfg_shift = 5'd3;
        i_cfg_load  = 1'b1;
        total_cnt++; if (o_busy !== 1'b1) $display("FAIL cb_busy got=%0b exp=1", o_busy); else pass_cnt++;
        tick();
        i_cfg_load = 1'b0;
        total_cnt++; if (o_cfg_err !== 1'b1) $display("FAIL cb_err got=%0b exp=1", o_cfg_err); else pass_cnt++;
        total_cnt++; if (o_bound_data !== pout(-50, 10, 127)) $display("FAIL cb_data got=%h exp=%h", o_bound_data, pout(-50, 10, 127)); else pass_cnt++;
        tick();
        total_cnt++; if (o_cfg_err !== 1'b0) $display("FAIL cb_err_pulse got=%0b exp=0", o_cfg_err); else pass_cnt++;
        total_cnt++; if (o_sat_cnt !== 16'd1) $display("FAIL cb_cnt got=%0d exp=1", o_sat_cnt); else pass_cnt++;
        send_beat(-50, -7, 3);
        total_cnt++; if (o_bound_data !== pout(-50, -7, 3)) $display("FAIL cb_oldmode got=%h exp=%h", o_bound_data, pout(-50, -7, 3)); else pass_cnt++;
        tick();
        // load colliding with an accepted beat while idle is also rejected
        i_acc_bias  = pin(-1, 2, 3);
        i_valid     = 1'b1;
        i_cfg_mode  = 2'b01;
        i_cfg_shift = 5'd0;
        i_cfg_load  = 1'b1;
        tick();
        i_valid    = 1'b0;
        i_cfg_load = 1'b0;
        total_cnt++; if (o_cfg_err !== 1'b1) $display("FAIL ca_err got=%0b exp=1", o_cfg_err); else pass_cnt++;
        tick();
        total_cnt++; if (o_bound_data !== pout(-1, 2, 3)) $display("FAIL ca_data got=%h exp=%h", o_bound_data, pout(-1, 2, 3)); else pass_cnt++;
        tick();
        load_cfg(2'b10, 5'd31);
        total_cnt++; if (o_cfg_err !== 1'b0) $display("FAIL clamp_err got=%0b exp=0", o_cfg_err); else pass_cnt++;
        total_cnt++; if (o_sat_cnt !== 16'd0) $display("FAIL clamp_cnt got=%0d exp=0", o_sat_cnt); else pass_cnt++;
        send_beat(524288, 524287, -524289);
        total_cnt++; if (o_bound_data !== pout(1, 0, -1)) $display("FAIL clamp_data got=%h exp=%h", o_bound_data, pout(1, 0, -1)); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midstream();
        load_cfg(2'b01, 5'd0);
        send_beat(300, 1, 1);
        total_cnt++; if (o_bound_data !== pout(127, 1, 1)) $display("FAIL mr_pre_data got=%h exp=%h", o_bound_data, pout(127, 1, 1)); else pass_cnt++;
        tick();
        total_cnt++; if (o_sat_cnt !== 16'd1) $display("FAIL mr_pre_cnt got=%0d exp=1", o_sat_cnt); else pass_cnt++;
        i_ready    = 1'b0;
        i_acc_bias = pin(5, 5, 5);
        i_valid    = 1'b1;
        tick();
        i_acc_bias = pin(6, 6, 6);
        tick();
        i_valid = 1'b0;
        total_cnt++; if (o_ready !== 1'b0) $display("FAIL mr_full_ready got=%0b exp=0", o_ready); else pass_cnt++;
        total_cnt++; if (o_valid !== 1'b1) $display("FAIL mr_full_valid got=%0b exp=1", o_valid); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL mr_valid got=%0b exp=0", o_valid); else pass_cnt++;
        total_cnt++; if (o_bound_data !== '0) $display("FAIL mr_data got=%h exp=0", o_bound_data); else pass_cnt++;
        total_cnt++; if (o_sat_cnt !== 16'd0) $display("FAIL mr_cnt got=%0d exp=0", o_sat_cnt); else pass_cnt++;
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL mr_busy got=%0b exp=0", o_busy); else pass_cnt++;
        i_ready = 1'b1;
        send_beat(200, -5, 7);
        total_cnt++; if (o_bound_data !== pout(127, -5, 7)) $display("FAIL mr_post_data got=%h exp=%h", o_bound_data, pout(127, -5, 7)); else pass_cnt++;
        tick();
        total_cnt++; if (o_sat_cnt !== 16'd1) $display("FAIL mr_post_cnt got=%0d exp=1", o_sat_cnt); else pass_cnt++;
    endtask

    initial begin
        rst         = 1'b1;
        i_cfg_load  = 1'b0;
        i_cfg_mode  = 2'b00;
        i_cfg_shift = '0;
        i_valid     = 1'b0;
        i_ready     = 1'b1;
        i_acc_bias  = '0;
        test_reset();
        test_saturate();
        test_relu_b2b();
        test_shift();
        test_back_to_back();
        test_cfg_busy();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
